// File: rtl/chs_pkg.sv
// Shared definitions for the cool/heat sequencer: state encoding, chs_conf
// field layout, mode values, default parameters and the power helper.
package chs_pkg;

    typedef logic signed [8:0] diff_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RAMP_UP   = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_DWELL     = 3'd4;

    localparam int MODE_BIT  = 7;
    localparam int POWER_MSB = 3;

    localparam logic MODE_COOL = 1'b1;
    localparam logic MODE_HEAT = 1'b0;

    localparam int DEF_HYST      = 2;
    localparam int DEF_RAMP_STEP = 16;
    localparam int DEF_RAMP_DIV  = 4;
    localparam int DEF_MIN_DWELL = 16;

    // Power is the error magnitude clipped to the 4-bit power field.
    function automatic logic [3:0] calc_power(input diff_t diff);
        logic [8:0] mag;
        mag = diff[8] ? 9'(-diff) : 9'(diff);
        return (mag > 9'd15) ? 4'hF : mag[3:0];
    endfunction

endpackage

// File: rtl/chs_sequencer_if.sv
// Control and status bundle between the sequencer and its host: demand
// inputs in, ModePower/FanSpeed command words and debug state out.
interface chs_sequencer_if;

    logic       enable;
    logic       temp_valid;
    logic [7:0] temp;
    logic [7:0] setpoint;
    logic [7:0] chs_conf;
    logic [7:0] speed;
    logic [2:0] state;

    modport master (
        output enable, temp_valid, temp, setpoint,
        input  chs_conf, speed, state
    );

    modport slave (
        input  enable, temp_valid, temp, setpoint,
        output chs_conf, speed, state
    );

endinterface

// File: rtl/chs_ramp.sv
// Fan speed soft-start/soft-stop: a tick divider plus a register that steps
// toward the target by RAMP_STEP per tick without overshooting.
module chs_ramp
    import chs_pkg::*;
#(
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int RAMP_DIV  = DEF_RAMP_DIV
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] target,
    input  logic       run,
    input  logic       clear_tick,
    output logic [7:0] speed,
    output logic       at_target
);

    localparam int              CW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(RAMP_DIV - 1);
    localparam logic [7:0]      STEP      = 8'(RAMP_STEP);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    speed_q, speed_d;
    logic          tick;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        tick_cnt_d = tick_cnt_q;
        speed_d    = speed_q;
        tick       = 1'b0;

        // A clear on phase entry also suppresses any step on that same edge.
        if (clear_tick) begin
            tick_cnt_d = '0;
        end else if (run) begin
            tick       = (tick_cnt_q == TICK_LAST);
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end

        if (tick) begin
            if (speed_q < target) begin
                speed_d = ((target - speed_q) <= STEP) ? target : speed_q + STEP;
            end else if (speed_q > target) begin
                speed_d = ((speed_q - target) <= STEP) ? target : speed_q - STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (arst) begin
            tick_cnt_q <= '0;
            speed_q    <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            speed_q    <= speed_d;
        end
    end

    assign speed     = speed_q;
    assign at_target = (speed_q == target);

endmodule

// File: rtl/chs_sequencer.sv
// Closed-loop cool/heat sequencer: hysteretic mode decision, soft-started fan
// speed and a mandatory off-dwell between runs.
module chs_sequencer
    import chs_pkg::*;
#(
    parameter int HYST      = DEF_HYST,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int RAMP_DIV  = DEF_RAMP_DIV,
    parameter int MIN_DWELL = DEF_MIN_DWELL
) (
    input  logic            clk,
    input  logic            arst,
    chs_sequencer_if.slave  bus
);

    localparam diff_t         HYST_POS   = diff_t'(HYST);
    localparam diff_t         HYST_NEG   = diff_t'(-HYST);
    localparam int            DW         = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(MIN_DWELL - 1);

    logic [2:0]    state_q, state_d;
    logic          mode_q, mode_d;
    diff_t         diff_q, diff_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [7:0]    chs_conf_q, chs_conf_d;

    logic [3:0]    power;
    logic [7:0]    target;
    logic          ramp_run;
    logic          clear_tick;
    logic [7:0]    speed;
    logic          at_target;
    logic          satisfied;

    assign power     = calc_power(diff_q);
    assign target    = (state_q == ST_RAMP_UP || state_q == ST_RUN) ? {power, 4'b0000} : 8'h00;
    assign ramp_run  = (state_q == ST_RAMP_UP) || (state_q == ST_RUN) || (state_q == ST_RAMP_DOWN);
    assign satisfied = (mode_q == MODE_COOL) ? (diff_q <= 9'sd0) : (diff_q >= 9'sd0);

    // The sample is stored in every state, including DWELL and an enable drop.
    assign diff_d = bus.temp_valid ? $signed({1'b0, bus.temp}) - $signed({1'b0, bus.setpoint})
                                   : diff_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable && diff_q > HYST_POS) begin
                    state_d = ST_RAMP_UP;
                    mode_d  = MODE_COOL;
                end else if (bus.enable && diff_q < HYST_NEG) begin
                    state_d = ST_RAMP_UP;
                    mode_d  = MODE_HEAT;
                end
            end
            ST_RAMP_UP: begin
                if (!bus.enable)    state_d = ST_RAMP_DOWN;
                else if (at_target) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.enable || satisfied) state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (at_target) state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (dwell_cnt_q == DWELL_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clear_tick  = (state_d != state_q) &&
                         (state_d == ST_RAMP_UP || state_d == ST_RAMP_DOWN);
    assign dwell_cnt_d = (state_q == ST_DWELL) ? dwell_cnt_q + 1'b1 : '0;

    always_comb begin
        chs_conf_d = 8'h00;
        if (state_d == ST_RAMP_UP || state_d == ST_RUN) begin
            chs_conf_d[MODE_BIT]       = mode_d;
            chs_conf_d[POWER_MSB:0]    = power;
        end else if (state_d == ST_RAMP_DOWN) begin
            chs_conf_d[MODE_BIT]       = mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_HEAT;
            diff_q      <= '0;
            dwell_cnt_q <= '0;
            chs_conf_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            diff_q      <= diff_d;
            dwell_cnt_q <= dwell_cnt_d;
            chs_conf_q  <= chs_conf_d;
        end
    end

    chs_ramp #(
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV)
    ) u_ramp (
        .clk        (clk),
        .arst       (arst),
        .target     (target),
        .run        (ramp_run),
        .clear_tick (clear_tick),
        .speed      (speed),
        .at_target  (at_target)
    );

    assign bus.chs_conf = chs_conf_q;
    assign bus.speed    = speed;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_chs_sequencer.sv
// Bench for chs_sequencer: a cycle-level reference model checked every cycle,
// a table of first-decision vectors, hand-written corner sequences and random traffic.
module tb_chs_sequencer;

    localparam int HYST      = 2;
    localparam int RAMP_STEP = 16;
    localparam int RAMP_DIV  = 4;
    localparam int MIN_DWELL = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RU   = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_DW   = 3'd4;

    logic clk;
    logic arst;
    chs_sequencer_if bus();

    chs_sequencer #(
        .HYST      (HYST),
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV),
        .MIN_DWELL (MIN_DWELL)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: phase plus time since the last phase entry, in plain ints.
    int m_state, m_mode, m_diff, m_speed, m_conf, m_age, m_dwell;

    function automatic int toward(input int s, input int t);
        if (s < t) return (s + RAMP_STEP > t) ? t : s + RAMP_STEP;
        if (s > t) return (s - RAMP_STEP < t) ? t : s - RAMP_STEP;
        return s;
    endfunction

    function automatic void model_reset();
        m_state = S_IDLE; m_mode = 0; m_diff = 0; m_speed = 0;
        m_conf = 0; m_age = 0; m_dwell = 0;
    endfunction

    function automatic void model_step();
        int nd, mag, pw, tgt, nxt;
        if (arst) begin
            model_reset();
            return;
        end
        nd  = bus.temp_valid ? int'(bus.temp) - int'(bus.setpoint) : m_diff;
        mag = (m_diff < 0) ? -m_diff : m_diff;
        pw  = (mag > 15) ? 15 : mag;
        tgt = (m_state == S_RU || m_state == S_RUN) ? pw * 16 : 0;
        nxt = m_state;
        case (m_state)
            S_IDLE: begin
                if (bus.enable && m_diff > HYST)       begin nxt = S_RU; m_mode = 1; end
                else if (bus.enable && m_diff < -HYST) begin nxt = S_RU; m_mode = 0; end
            end
            S_RU:  if (!bus.enable) nxt = S_RD; else if (m_speed == tgt) nxt = S_RUN;
            S_RUN: if (!bus.enable || (m_mode == 1 ? m_diff <= 0 : m_diff >= 0)) nxt = S_RD;
            S_RD:  if (m_speed == 0) nxt = S_DW;
            S_DW:  if (m_dwell + 1 == MIN_DWELL) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (nxt != m_state && (nxt == S_RU || nxt == S_RD)) begin
            m_age = 0;
        end else if (m_state == S_RU || m_state == S_RUN || m_state == S_RD) begin
            m_age++;
            if (m_age % RAMP_DIV == 0) m_speed = toward(m_speed, tgt);
        end
        m_dwell = (m_state == S_DW) ? m_dwell + 1 : 0;
        if (nxt == S_RU || nxt == S_RUN) m_conf = m_mode * 128 + pw;
        else if (nxt == S_RD)            m_conf = m_mode * 128;
        else                             m_conf = 0;
        m_diff  = nd;
        m_state = nxt;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model state", 32'(bus.state), m_state);
        check("model speed", 32'(bus.speed), m_speed);
        check("model chs_conf", 32'(bus.chs_conf), m_conf);
    endtask

    task automatic pulse(input logic [7:0] t);
        bus.temp       = t;
        bus.temp_valid = 1'b1;
        cycle();
        bus.temp_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.temp_valid = 1'b0;
        arst = 1'b1;
        cycle();
        cycle();
        arst = 1'b0;
    endtask

    task automatic wait_state(input string name, input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (bus.state !== s && n < budget) begin
            cycle();
            n++;
        end
        check(name, 32'(bus.state), 32'(s));
    endtask

    typedef struct {
        string      name;
        logic       en;
        logic [7:0] temp;
        logic [2:0] st;
        logic [7:0] conf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        arst           = 1'b1;
        bus.enable     = 1'b0;
        bus.temp_valid = 1'b0;
        bus.temp       = 8'd22;
        bus.setpoint   = 8'd22;

        vecs[0]  = '{"cool 30",    1'b1, 8'd30,  S_RU,   8'h88};
        vecs[1]  = '{"hyst 21",    1'b1, 8'd21,  S_IDLE, 8'h00};
        vecs[2]  = '{"hyst 24",    1'b1, 8'd24,  S_IDLE, 8'h00};
        vecs[3]  = '{"cool 25",    1'b1, 8'd25,  S_RU,   8'h83};
        vecs[4]  = '{"hyst 20",    1'b1, 8'd20,  S_IDLE, 8'h00};
        vecs[5]  = '{"heat 19",    1'b1, 8'd19,  S_RU,   8'h03};
        vecs[6]  = '{"cool 60",    1'b1, 8'd60,  S_RU,   8'h8F};
        vecs[7]  = '{"cool 37",    1'b1, 8'd37,  S_RU,   8'h8F};
        vecs[8]  = '{"cool 36",    1'b1, 8'd36,  S_RU,   8'h8E};
        vecs[9]  = '{"heat 0",     1'b1, 8'd0,   S_RU,   8'h0F};
        vecs[10] = '{"cool 255",   1'b1, 8'd255, S_RU,   8'h8F};
        vecs[11] = '{"disabled",   1'b0, 8'd30,  S_IDLE, 8'h00};

        // Reset state
        do_reset();
        check("reset state", 32'(bus.state), 32'(S_IDLE));
        check("reset speed", 32'(bus.speed), 32'd0);
        check("reset chs_conf", 32'(bus.chs_conf), 32'h00);

        // First decision per vector, one edge after the sample edge
        for (int i = 0; i < 12; i++) begin
            do_reset();
            bus.enable = vecs[i].en;
            pulse(vecs[i].temp);
            cycle();
            check({vecs[i].name, " state"}, 32'(bus.state), 32'(vecs[i].st));
            check({vecs[i].name, " chs_conf"}, 32'(bus.chs_conf), 32'(vecs[i].conf));
        end

        // Cool start: 8 ticks of 16, then RUN; then reset during RUN
        do_reset();
        bus.enable = 1'b1;
        pulse(8'd30);
        check("cool sample edge state", 32'(bus.state), 32'(S_IDLE));
        cycle();
        check("cool entry chs_conf", 32'(bus.chs_conf), 32'h88);
        for (int k = 1; k <= 8; k++) begin
            repeat (RAMP_DIV) cycle();
            check("cool ramp speed", 32'(bus.speed), 32'(16 * k));
        end
        check("cool still ramping", 32'(bus.state), 32'(S_RU));
        cycle();
        check("cool run", 32'(bus.state), 32'(S_RUN));
        arst = 1'b1;
        cycle();
        check("mid reset state", 32'(bus.state), 32'(S_IDLE));
        check("mid reset speed", 32'(bus.speed), 32'd0);
        check("mid reset chs_conf", 32'(bus.chs_conf), 32'h00);
        cycle();
        cycle();
        arst = 1'b0;
        cycle();
        check("after reset idle", 32'(bus.state), 32'(S_IDLE));

        // Hysteresis then heat
        pulse(8'd21);
        repeat (3) cycle();
        check("hyst keeps idle", 32'(bus.state), 32'(S_IDLE));
        pulse(8'd19);
        cycle();
        check("heat chs_conf", 32'(bus.chs_conf), 32'h03);
        repeat (3 * RAMP_DIV) cycle();
        check("heat speed 48", 32'(bus.speed), 32'd48);
        cycle();
        check("heat run", 32'(bus.state), 32'(S_RUN));

        // Satisfy, dwell, sample during dwell acted on only after IDLE
        do_reset();
        pulse(8'd30);
        wait_state("satisfy reach run", S_RUN, 60);
        pulse(8'd22);
        cycle();
        check("satisfy ramp down", 32'(bus.state), 32'(S_RD));
        check("satisfy chs_conf", 32'(bus.chs_conf), 32'h80);
        repeat (RAMP_DIV) cycle();
        check("satisfy speed 112", 32'(bus.speed), 32'd112);
        wait_state("satisfy dwell", S_DW, 60);
        check("dwell speed", 32'(bus.speed), 32'd0);
        pulse(8'd30);
        repeat (MIN_DWELL - 2) cycle();
        check("dwell holds", 32'(bus.state), 32'(S_DW));
        cycle();
        check("dwell to idle", 32'(bus.state), 32'(S_IDLE));
        cycle();
        check("restart after dwell", 32'(bus.state), 32'(S_RU));
        check("restart chs_conf", 32'(bus.chs_conf), 32'h88);

        // Saturation at 240, then re-target down to 48 inside RUN
        do_reset();
        pulse(8'd60);
        wait_state("sat reach run", S_RUN, 80);
        check("sat speed", 32'(bus.speed), 32'd240);
        check("sat chs_conf", 32'(bus.chs_conf), 32'h8F);
        pulse(8'd25);
        cycle();
        check("retarget chs_conf", 32'(bus.chs_conf), 32'h83);
        repeat (60) cycle();
        check("retarget speed", 32'(bus.speed), 32'd48);
        check("retarget stays run", 32'(bus.state), 32'(S_RUN));

        // Enable drop coinciding with temp_valid and a due tick in RAMP_UP
        do_reset();
        pulse(8'd30);
        cycle();
        repeat (7) cycle();
        check("drop pre speed", 32'(bus.speed), 32'd16);
        bus.enable = 1'b0;
        pulse(8'd40);
        check("drop ramp down", 32'(bus.state), 32'(S_RD));
        check("drop no increment", 32'(bus.speed), 32'd16);
        check("drop chs_conf", 32'(bus.chs_conf), 32'h80);
        wait_state("drop reach idle", S_IDLE, 60);
        bus.enable = 1'b1;
        cycle();
        check("drop sample kept", 32'(bus.chs_conf), 32'h8F);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            bus.temp_valid = ($urandom_range(0, 5) == 0);
            if (bus.temp_valid) begin
                bus.temp = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 50));
            end
            if ($urandom_range(0, 39) == 0)  bus.enable = ~bus.enable;
            if ($urandom_range(0, 299) == 0) bus.setpoint = 8'($urandom_range(10, 40));
            arst = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/chs_sequencer.md
# chs_sequencer

Closed-loop sequencer for the cool/heat system. It compares a sampled temperature against a setpoint and chooses cool, heat or off, with hysteresis. It drives the 8-bit `chs_conf` word consumed by ModePower and the 8-bit `speed` word consumed by FanSpeed. Fan speed is soft-started and soft-stopped, and a mandatory off-dwell separates successive runs.

## Interface
- `HYST`, default 2: hysteresis in degrees; demand starts only when |temp − setpoint| > HYST.
- `RAMP_STEP`, default 16: speed increment or decrement per ramp tick.
- `RAMP_DIV`, default 4: clock cycles per ramp tick.
- `MIN_DWELL`, default 16: cycles spent in DWELL, with all outputs off, after every run.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `arst`, input, 1: reset; synchronous, active-high.
- `enable`, input, 1: master enable; low forces shutdown through RAMP_DOWN.
- `temp_valid`, input, 1: single-cycle strobe; `temp` is sampled on this edge.
- `temp`, input, 8: measured temperature, unsigned degrees.
- `setpoint`, input, 8: target temperature, unsigned degrees.
- `chs_conf`, output, 8: bit7 = mode (1 cool, 0 heat); bits6:4 = 0; bits3:0 = power.
- `speed`, output, 8: fan speed command to FanSpeed.
- `state`, output, 3: current FSM state, for debug and verification.

## Operation
- Error is `diff = temp − setpoint`, computed as 9-bit signed and registered on each `temp_valid` edge.
- Power is min(|diff|, 15).
- Speed target is {power, 4'b0000}, so the maximum is 240.
- FSM states:
  - IDLE: `chs_conf` = 0, `speed` = 0.
    - Go to RAMP_UP if `enable` and diff > HYST (mode latched cool).
    - Go to RAMP_UP if `enable` and diff < −HYST (mode latched heat).
    - |diff| ≤ HYST keeps the block in IDLE.
  - RAMP_UP: `chs_conf` = {mode, 000, power}.
    - Each tick, `speed` += RAMP_STEP, saturating at the target (never overshoots).
    - Go to RUN when `speed` == target.
  - RUN: `chs_conf` power and the target update on each new sample.
    - `speed` ramps toward the target in either direction at the same tick rate.
    - Cool exits to RAMP_DOWN when diff ≤ 0; heat exits when diff ≥ 0.
    - Loss of `enable` or opposite-sign demand also exits to RAMP_DOWN.
  - RAMP_DOWN: `chs_conf` = {mode, 000, 0000}.
    - Each tick, `speed` −= RAMP_STEP, saturating at 0.
    - Go to DWELL when `speed` == 0.
  - DWELL: `chs_conf` = 0, `speed` = 0.
    - Counts MIN_DWELL cycles, then goes to IDLE.
    - Demand and `temp_valid` during DWELL are ignored; the last sample is still stored.
- A mode change always passes RAMP_DOWN → DWELL → IDLE before the new mode is latched; there is no direct cool↔heat path.
- Loss of `enable` in RAMP_UP also exits to RAMP_DOWN.
- If `enable` falls in the same cycle as `temp_valid`, `enable` wins: the block goes to RAMP_DOWN and the sample is still stored.
- If the target changes mid-ramp, the ramp follows the new target from the next tick.

## Timing
- `temp_valid` at edge N registers diff at N.
- The FSM transition and `chs_conf` update happen at edge N+1, a 1-cycle decision latency.
- The ramp tick counter clears on entry to RAMP_UP or RAMP_DOWN. The first step occurs RAMP_DIV cycles after entry, then one step every RAMP_DIV cycles.
- In RUN the tick counter free-runs.
- The DWELL counter clears on entry; IDLE is reached exactly MIN_DWELL cycles after DWELL entry.
- All outputs are registered.
- Reset values: `chs_conf` = 8'h00, `speed` = 8'h00, `state` = IDLE, all counters 0, stored diff 0.
- `arst` asserted mid-operation takes effect at the next edge, overriding every other condition. No ramp-down occurs.

## Structure
- Shared package `chs_pkg` holds:
  - state encoding: IDLE = 0, RAMP_UP = 1, RUN = 2, RAMP_DOWN = 3, DWELL = 4;
  - `chs_conf` field positions (MODE_BIT = 7, POWER_MSB = 3);
  - MODE_COOL = 1, MODE_HEAT = 0;
  - default parameter values.
- Sub-module `chs_ramp` holds the tick divider plus the saturating step-toward-target register.
  - Inputs: `target`, `run`, `clear_tick`.
  - Output: `speed`, `at_target`.
- The FSM, error register and dwell counter live in the top level.

## Test plan
All scenarios use default parameters and `setpoint` = 22.
- Reset: `arst` high for 3 cycles during RUN → next edge `chs_conf` = 8'h00, `speed` = 0, `state` = IDLE.
- Cool start: `enable` = 1, `temp` = 30 with `temp_valid` → `chs_conf` = 8'h88 one edge later. `speed` climbs 16, 32, … 128 in 8 ticks (32 cycles), then `state` = RUN.
- Hysteresis and heat: `temp` = 21 → stays IDLE. Then `temp` = 19 → `chs_conf` = 8'h03, target 48, RUN after 3 ticks.
- Satisfy: in cool RUN at speed 128, `temp` = 22 → RAMP_DOWN, `chs_conf` = 8'h80, speed falls 16 per 4 cycles to 0. Then DWELL for 16 cycles; `temp` = 30 sampled during DWELL restarts cooling only after IDLE.
- Saturation and re-target: `temp` = 60 → `chs_conf` = 8'h8F, speed reaches 240. Then `temp` = 25 in RUN → `chs_conf` = 8'h83, speed ramps down to 48 and stays in RUN.
- Enable drop: deassert `enable` in the same cycle as `temp_valid` during RAMP_UP → RAMP_DOWN next edge, with no further increments.
